// File: rtl/conv3x3_rgb565_engine_if.sv
// Window/coefficient/output bundle for conv3x3_rgb565_engine.
// master = window source and coefficient writer, slave = engine.
interface conv3x3_rgb565_engine_if #(
  parameter int COEF_W = 8
);
  logic [8:0][15:0]   in_pixels;
  logic               in_valid;
  logic               in_sof;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic [COEF_W-1:0]  coef_data;
  logic               coef_commit;
  logic [15:0]        out_pixel;
  logic               out_valid;
  logic               out_sof;
  logic               coef_pending;

  modport master (
    output in_pixels, in_valid, in_sof,
    output coef_we, coef_addr, coef_data, coef_commit,
    input  out_pixel, out_valid, out_sof, coef_pending
  );

  modport slave (
    input  in_pixels, in_valid, in_sof,
    input  coef_we, coef_addr, coef_data, coef_commit,
    output out_pixel, out_valid, out_sof, coef_pending
  );
endinterface

// File: rtl/conv3x3_rgb565_engine.sv
// 4-stage 3x3 RGB565 convolution, edge replication, double-buffered kernel.
// Ports: clk, reset (async high), bus (window in, coef write, pixel out).
module conv3x3_rgb565_engine #(
  parameter int IMG_WIDTH = 640,
  parameter int COEF_W    = 8
) (
  input logic clk,
  input logic reset,
  conv3x3_rgb565_engine_if.slave bus
);
  localparam int AW = COEF_W + 10;
  localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [AW-1:0]     acc_t;

  localparam acc_t MAX5 = acc_t'(31);
  localparam acc_t MAX6 = acc_t'(63);

  coef_t      sh_k [9];
  logic [3:0] sh_shift;
  coef_t      ac_k [9];
  logic [3:0] ac_shift;
  logic       pending;

  logic [CW-1:0] col;
  logic [CW-1:0] eff_col;
  logic          at_left;
  logic          at_right;
  logic          swap;

  always_comb begin
    eff_col  = bus.in_sof ? '0 : col;
    at_left  = (eff_col == '0);
    at_right = (eff_col == LAST);
    // a commit arriving with the sof window already counts for it
    swap     = bus.in_valid && bus.in_sof
             && (pending || bus.coef_commit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
    end else if (bus.in_valid) begin
      col <= at_right ? '0 : eff_col + 1'b1;
    end
  end

  // copy reads the shadow as it was before any same-cycle write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        sh_k[i] <= (i == 4) ? coef_t'(1) : '0;
        ac_k[i] <= (i == 4) ? coef_t'(1) : '0;
      end
      sh_shift <= '0;
      ac_shift <= '0;
      pending  <= 1'b0;
    end else begin
      if (swap) begin
        ac_k     <= sh_k;
        ac_shift <= sh_shift;
      end
      if (bus.coef_we) begin
        if (bus.coef_addr < 4'd9)
          sh_k[bus.coef_addr] <= bus.coef_data;
        else if (bus.coef_addr == 4'd9)
          sh_shift <= bus.coef_data[3:0];
      end
      if (swap)
        pending <= 1'b0;
      else if (bus.coef_commit)
        pending <= 1'b1;
    end
  end

  logic [15:0] win [9];
  coef_t       k_use [9];
  logic [3:0]  shift_use;
  acc_t        prod_d [3][9];
  acc_t        kx;
  acc_t        cr;
  acc_t        cg;
  acc_t        cb;

  // outer columns fold onto the centre column at image borders
  always_comb begin
    shift_use = swap ? sh_shift : ac_shift;
    kx = '0;
    cr = '0;
    cg = '0;
    cb = '0;
    for (int r = 0; r < 3; r++) begin
      win[3*r]   = at_left  ? bus.in_pixels[3*r+1]
                            : bus.in_pixels[3*r];
      win[3*r+1] = bus.in_pixels[3*r+1];
      win[3*r+2] = at_right ? bus.in_pixels[3*r+1]
                            : bus.in_pixels[3*r+2];
    end
    for (int i = 0; i < 9; i++) begin
      k_use[i] = swap ? sh_k[i] : ac_k[i];
      kx = {{(AW-COEF_W){k_use[i][COEF_W-1]}}, k_use[i]};
      cr = {{(AW-5){1'b0}}, win[i][15:11]};
      cg = {{(AW-6){1'b0}}, win[i][10:5]};
      cb = {{(AW-5){1'b0}}, win[i][4:0]};
      prod_d[0][i] = cr * kx;
      prod_d[1][i] = cg * kx;
      prod_d[2][i] = cb * kx;
    end
  end

  acc_t       prod_q [3][9];
  logic       s1_valid;
  logic       s1_sof;
  logic [3:0] s1_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 9; i++)
          prod_q[c][i] <= '0;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_shift <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_sof   <= bus.in_valid && bus.in_sof;
      if (bus.in_valid) begin
        prod_q   <= prod_d;
        s1_shift <= shift_use;
      end
    end
  end

  acc_t       row_q [3][3];
  logic       s2_valid;
  logic       s2_sof;
  logic [3:0] s2_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          row_q[c][r] <= '0;
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_shift <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      if (s1_valid) begin
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 3; r++)
            row_q[c][r] <= prod_q[c][3*r]
                         + prod_q[c][3*r+1]
                         + prod_q[c][3*r+2];
        s2_shift <= s1_shift;
      end
    end
  end

  acc_t       tot_q [3];
  logic       s3_valid;
  logic       s3_sof;
  logic [3:0] s3_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++)
        tot_q[c] <= '0;
      s3_valid <= 1'b0;
      s3_sof   <= 1'b0;
      s3_shift <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_sof   <= s2_sof;
      if (s2_valid) begin
        for (int c = 0; c < 3; c++)
          tot_q[c] <= row_q[c][0] + row_q[c][1] + row_q[c][2];
        s3_shift <= s2_shift;
      end
    end
  end

  function automatic logic [5:0] sat(input acc_t v, input acc_t maxv);
    if (v[AW-1])
      sat = '0;
    else if (v > maxv)
      sat = maxv[5:0];
    else
      sat = v[5:0];
  endfunction

  acc_t        shr [3];
  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;
  logic [15:0] px_d;

  always_comb begin
    for (int c = 0; c < 3; c++)
      shr[c] = tot_q[c] >>> s3_shift;
    r5   = 5'(sat(shr[0], MAX5));
    g6   = sat(shr[1], MAX6);
    b5   = 5'(sat(shr[2], MAX5));
    px_d = {r5, g6, b5};
  end

  logic [15:0] out_pixel_q;
  logic        out_valid_q;
  logic        out_sof_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_pixel_q <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      out_valid_q <= s3_valid;
      out_sof_q   <= s3_sof;
      if (s3_valid)
        out_pixel_q <= px_d;
    end
  end

  assign bus.out_pixel    = out_pixel_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sof      = out_sof_q;
  assign bus.coef_pending = pending;

endmodule

// File: tb/tb_conv3x3_rgb565_engine.sv
// Scoreboard bench for conv3x3_rgb565_engine.
// Directed windows with hand-computed pixels; monitor checks order/latency.
module tb_conv3x3_rgb565_engine;
  localparam int W = 640;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv3x3_rgb565_engine_if #(.COEF_W(8)) bus ();

  conv3x3_rgb565_engine #(
    .IMG_WIDTH(W),
    .COEF_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] px;
    logic        sof;
    int          cyc;
  } exp_t;

  typedef logic [8:0][15:0] win_t;
  typedef logic [8:0][7:0]  ker_t;

  exp_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic win_t fill(input logic [15:0] ctr,
                                input logic [15:0] nb);
    win_t w;
    for (int i = 0; i < 9; i++)
      w[i] = (i == 4) ? ctr : nb;
    return w;
  endfunction

  function automatic ker_t kern(input logic [7:0] ctr,
                                input logic [7:0] nb);
    ker_t k;
    for (int i = 0; i < 9; i++)
      k[i] = (i == 4) ? ctr : nb;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input win_t w, input logic sof,
                      input logic commit, input logic push,
                      input logic [15:0] exp);
    exp_t e;
    bus.in_pixels   = w;
    bus.in_valid    = 1'b1;
    bus.in_sof      = sof;
    bus.coef_commit = commit;
    if (push) begin
      e.px  = exp;
      e.sof = sof;
      e.cyc = cyc + 4;
      q.push_back(e);
    end
    tick();
    bus.in_valid    = 1'b0;
    bus.in_sof      = 1'b0;
    bus.coef_commit = 1'b0;
    bus.coef_we     = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = d;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic load(input ker_t k, input logic [3:0] sh);
    for (int i = 0; i < 9; i++)
      wr(4'(i), k[i]);
    wr(4'd9, {4'd0, sh});
  endtask

  task automatic commit();
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h want none",
                 bus.out_pixel);
      end else begin
        e = q.pop_front();
        chk("out_pixel", {16'd0, bus.out_pixel}, {16'd0, e.px});
        chk("out_sof", {31'd0, bus.out_sof}, {31'd0, e.sof});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    win_t w;
    ker_t k;

    bus.in_pixels   = '0;
    bus.in_valid    = 1'b0;
    bus.in_sof      = 1'b0;
    bus.coef_we     = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_data   = '0;
    bus.coef_commit = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_pixel", {16'd0, bus.out_pixel}, 32'd0);
    chk("rst_out_sof", {31'd0, bus.out_sof}, 32'd0);
    chk("rst_pending", {31'd0, bus.coef_pending}, 32'd0);
    tick();

    // identity kernel from reset
    for (int i = 0; i < 5; i++) begin
      for (int t = 0; t < 9; t++)
        w[t] = 16'($urandom);
      w[4] = 16'hF81F;
      send(w, i == 0, 1'b0, 1'b1, 16'hF81F);
    end
    idle(6);

    // box blur with saturation
    load(kern(8'd1, 8'd1), 4'd3);
    commit();
    chk("box_pending", {31'd0, bus.coef_pending}, 32'd1);
    send(fill(16'hFFFF, 16'hFFFF), 1'b1, 1'b0, 1'b1, 16'hFFFF);
    chk("box_pending_clr", {31'd0, bus.coef_pending}, 32'd0);
    send(fill(16'h0841, 16'h0841), 1'b0, 1'b0, 1'b1, 16'h0841);
    idle(6);

    // Laplacian, commit coincident with sof
    load(kern(8'd8, 8'hFF), 4'd0);
    send(fill(16'h0000, 16'hFFFF), 1'b1, 1'b1, 1'b1, 16'h0000);
    chk("lap_pending", {31'd0, bus.coef_pending}, 32'd0);
    send(fill(16'hFFFF, 16'h0000), 1'b0, 1'b0, 1'b1, 16'hFFFF);
    idle(6);

    // deferred commit mid-frame; write during copy stays in shadow
    load(kern(8'd1, 8'd0), 4'd0);
    commit();
    chk("def_pending", {31'd0, bus.coef_pending}, 32'd1);
    send(fill(16'h0841, 16'h0000), 1'b0, 1'b0, 1'b1, 16'h4208);
    chk("def_pending_hold", {31'd0, bus.coef_pending}, 32'd1);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'd4;
    bus.coef_data = 8'd3;
    send(fill(16'h0841, 16'h0000), 1'b1, 1'b0, 1'b1, 16'h0841);
    chk("def_pending_clr", {31'd0, bus.coef_pending}, 32'd0);
    send(fill(16'h0841, 16'h0000), 1'b0, 1'b0, 1'b1, 16'h0841);
    idle(6);

    // edge replication, k3 = k5 = 1
    k = kern(8'd0, 8'd0);
    k[3] = 8'd1;
    k[5] = 8'd1;
    load(k, 4'd0);
    commit();
    w = '0;
    w[3] = 16'h001F;
    w[4] = 16'h0001;
    send(w, 1'b1, 1'b0, 1'b1, 16'h0001);
    w = '0;
    w[3] = 16'h0003;
    w[5] = 16'h0004;
    send(w, 1'b0, 1'b0, 1'b1, 16'h0007);
    for (int c = 2; c < W - 1; c++)
      send('0, 1'b0, 1'b0, 1'b1, 16'h0000);
    w = '0;
    w[4] = 16'h0002;
    w[5] = 16'h001F;
    send(w, 1'b0, 1'b0, 1'b1, 16'h0002);
    w = '0;
    w[3] = 16'h001F;
    w[4] = 16'h0001;
    send(w, 1'b0, 1'b0, 1'b1, 16'h0001);
    idle(6);
    chk("hold_pixel", {16'd0, bus.out_pixel}, 32'h0001);
    chk("hold_valid", {31'd0, bus.out_valid}, 32'd0);

    // async reset with windows in flight
    send(fill(16'hFFFF, 16'hFFFF), 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    #1 reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_pixel", {16'd0, bus.out_pixel}, 32'd0);
    chk("arst_out_sof", {31'd0, bus.out_sof}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(6);
    send(fill(16'hF81F, 16'h1234), 1'b0, 1'b0, 1'b1, 16'hF81F);
    idle(6);

    chk("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
